// File: rtl/ppu_pkg.sv
// Shared PPU VRAM definitions: fetch kinds, region bases, responder states.
package ppu_pkg;

    typedef enum logic [1:0] {
        FK_NT     = 2'd0,
        FK_AT     = 2'd1,
        FK_BG_LSB = 2'd2,
        FK_BG_MSB = 2'd3
    } fetch_kind_e;

    typedef enum logic [1:0] {
        RG_CHR   = 2'd0,
        RG_CIRAM = 2'd1,
        RG_PAL   = 2'd2
    } region_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PPU_ACC  = 3'd1,
        ST_PPU_WAIT = 3'd2,
        ST_CPU_ACC  = 3'd3,
        ST_CPU_WAIT = 3'd4
    } state_e;

    localparam logic [13:0] NT_BASE  = 14'h2000;
    localparam logic [13:0] PAL_BASE = 14'h3F00;

endpackage

// File: rtl/ppu_addr_decode.sv
// PPU address decode: region select, nametable mirroring, palette index fold.
module ppu_addr_decode
    import ppu_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic [AW-1:0] addr_i,
    input  logic          mirror_vertical_i,
    output region_e       region_o,
    output logic [12:0]   chr_addr_o,
    output logic [10:0]   ciram_addr_o,
    output logic [4:0]    pal_idx_o
);

    always_comb begin
        region_o = RG_CHR;
        if (addr_i >= AW'(PAL_BASE)) begin
            region_o = RG_PAL;
        end else if (addr_i >= AW'(NT_BASE)) begin
            region_o = RG_CIRAM;
        end
    end

    assign chr_addr_o   = addr_i[12:0];
    assign ciram_addr_o = {mirror_vertical_i ? addr_i[10] : addr_i[11], addr_i[9:0]};
    // Backdrop entries $3F10/14/18/1C fold onto $3F00/04/08/0C
    assign pal_idx_o    = {addr_i[4] & (addr_i[1:0] != 2'b00), addr_i[3:0]};

endmodule

// File: rtl/ppu_vram_responder.sv
// PPU VRAM responder: serves renderer fetches with priority over CPU $2007
module ppu_vram_responder
    import ppu_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int AW     = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [1:0]    fetch_kind,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_valid,
    output logic [7:0]    fetch_data,
    output logic [1:0]    fetch_kind_out,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_ack,
    output logic [7:0]    cpu_rdata,
    input  logic          mirror_vertical,
    output logic [10:0]   ciram_addr,
    output logic          ciram_we,
    output logic [7:0]    ciram_wdata,
    input  logic [7:0]    ciram_rdata,
    output logic [12:0]   chr_addr,
    output logic          chr_rd,
    input  logic [7:0]    chr_rdata,
    output logic          overrun
);

    localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          pend_q, pend_d;
    fetch_kind_e   pend_kind_q, pend_kind_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    fetch_kind_e   cur_kind_q, cur_kind_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic          cur_we_q, cur_we_d;
    logic [7:0]    cur_wdata_q, cur_wdata_d;
    logic          fetch_valid_q, fetch_valid_d;
    logic [7:0]    fetch_data_q, fetch_data_d;
    logic [1:0]    fetch_kind_out_q, fetch_kind_out_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;
    logic          overrun_q, overrun_d;
    logic [5:0]    pal_q [32];

    region_e       region;
    logic [12:0]   dec_chr;
    logic [10:0]   dec_ciram;
    logic [4:0]    pal_idx;
    logic          in_acc, cpu_wr, pal_we, done, launch;
    logic [7:0]    rd_data;

    ppu_addr_decode #(.AW(AW)) u_dec (
        .addr_i            (cur_addr_q),
        .mirror_vertical_i (mirror_vertical),
        .region_o          (region),
        .chr_addr_o        (dec_chr),
        .ciram_addr_o      (dec_ciram),
        .pal_idx_o         (pal_idx)
    );

    assign in_acc = (state_q == ST_PPU_ACC) || (state_q == ST_CPU_ACC);
    assign cpu_wr = (state_q == ST_CPU_ACC) && cur_we_q;
    assign pal_we = cpu_wr && (region == RG_PAL);
    assign done   = ((state_q == ST_PPU_WAIT) || (state_q == ST_CPU_WAIT))
                    && (cnt_q == LAT_M1);

    assign chr_rd      = in_acc && (region == RG_CHR) && !cpu_wr;
    assign chr_addr    = (in_acc && (region == RG_CHR)) ? dec_chr : '0;
    assign ciram_addr  = (in_acc && (region == RG_CIRAM)) ? dec_ciram : '0;
    assign ciram_we    = cpu_wr && (region == RG_CIRAM);
    assign ciram_wdata = ciram_we ? cur_wdata_q : '0;

    always_comb begin
        rd_data = chr_rdata;
        if (region == RG_CIRAM) begin
            rd_data = ciram_rdata;
        end else if (region == RG_PAL) begin
            rd_data = {2'b00, pal_q[pal_idx]};
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        pend_d           = pend_q;
        pend_kind_d      = pend_kind_q;
        pend_addr_d      = pend_addr_q;
        cur_kind_d       = cur_kind_q;
        cur_addr_d       = cur_addr_q;
        cur_we_d         = cur_we_q;
        cur_wdata_d      = cur_wdata_q;
        fetch_valid_d    = 1'b0;
        fetch_data_d     = fetch_data_q;
        fetch_kind_out_d = fetch_kind_out_q;
        cpu_ack_d        = 1'b0;
        cpu_rdata_d      = cpu_rdata_q;
        overrun_d        = overrun_q;
        launch           = 1'b0;

        unique case (state_q)
            ST_IDLE: launch = 1'b1;
            ST_PPU_ACC: begin
                state_d = ST_PPU_WAIT;
                cnt_d   = '0;
            end
            ST_CPU_ACC: begin
                state_d = ST_CPU_WAIT;
                cnt_d   = '0;
            end
            ST_PPU_WAIT: begin
                cnt_d = cnt_q + 2'd1;
                if (done) begin
                    launch           = 1'b1;
                    fetch_valid_d    = 1'b1;
                    fetch_data_d     = rd_data;
                    fetch_kind_out_d = cur_kind_q;
                end
            end
            ST_CPU_WAIT: begin
                cnt_d = cnt_q + 2'd1;
                if (done) begin
                    launch    = 1'b1;
                    cpu_ack_d = 1'b1;
                    if (!cur_we_q) begin
                        cpu_rdata_d = rd_data;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The finishing CPU request is still held high this cycle and the ack cycle
        if (launch) begin
            if (pend_q) begin
                state_d     = ST_PPU_ACC;
                cur_addr_d  = pend_addr_q;
                cur_kind_d  = pend_kind_q;
                cur_we_d    = 1'b0;
                pend_d      = fetch_req;
                pend_addr_d = fetch_addr;
                pend_kind_d = fetch_kind_e'(fetch_kind);
            end else if (fetch_req) begin
                state_d    = ST_PPU_ACC;
                cur_addr_d = fetch_addr;
                cur_kind_d = fetch_kind_e'(fetch_kind);
                cur_we_d   = 1'b0;
            end else if (cpu_req && !cpu_ack_q && (state_q != ST_CPU_WAIT)) begin
                state_d     = ST_CPU_ACC;
                cur_addr_d  = cpu_addr;
                cur_we_d    = cpu_we;
                cur_wdata_d = cpu_wdata;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (fetch_req) begin
            if (!pend_q && ((state_q == ST_CPU_ACC) || (state_q == ST_CPU_WAIT))) begin
                pend_d      = 1'b1;
                pend_addr_d = fetch_addr;
                pend_kind_d = fetch_kind_e'(fetch_kind);
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            pend_q           <= 1'b0;
            pend_kind_q      <= FK_NT;
            pend_addr_q      <= '0;
            cur_kind_q       <= FK_NT;
            cur_addr_q       <= '0;
            cur_we_q         <= 1'b0;
            cur_wdata_q      <= '0;
            fetch_valid_q    <= 1'b0;
            fetch_data_q     <= '0;
            fetch_kind_out_q <= '0;
            cpu_ack_q        <= 1'b0;
            cpu_rdata_q      <= '0;
            overrun_q        <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                pal_q[i] <= '0;
            end
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            pend_q           <= pend_d;
            pend_kind_q      <= pend_kind_d;
            pend_addr_q      <= pend_addr_d;
            cur_kind_q       <= cur_kind_d;
            cur_addr_q       <= cur_addr_d;
            cur_we_q         <= cur_we_d;
            cur_wdata_q      <= cur_wdata_d;
            fetch_valid_q    <= fetch_valid_d;
            fetch_data_q     <= fetch_data_d;
            fetch_kind_out_q <= fetch_kind_out_d;
            cpu_ack_q        <= cpu_ack_d;
            cpu_rdata_q      <= cpu_rdata_d;
            overrun_q        <= overrun_d;
            if (pal_we) begin
                pal_q[pal_idx] <= cur_wdata_q[5:0];
            end
        end
    end

    assign fetch_valid    = fetch_valid_q;
    assign fetch_data     = fetch_data_q;
    assign fetch_kind_out = fetch_kind_out_q;
    assign cpu_ack        = cpu_ack_q;
    assign cpu_rdata      = cpu_rdata_q;
    assign overrun        = overrun_q;

endmodule
